// File: rtl/exu_mul_wb_buf.sv
// rtl/exu_mul_wb_buf.sv - multiplier E3 result FIFO with writeback handshake and issue credits
module exu_mul_wb_buf #(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          freeze,
    input  logic          mul_issue,
    input  logic          mul_valid_e3,
    input  logic [4:0]    mul_rd_e3,
    input  logic [31:0]   mul_result_e3,
    input  logic          wb_ready,
    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    output logic          mul_stall,
    output logic [CW-1:0] credits,
    output logic          overflow_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic issue;
    logic push_ok;
    logic push_drop;
    logic credit_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Freeze gates every event at its source, so the state update below needs no freeze term.
    assign push  = mul_valid_e3 & ~freeze;
    assign issue = mul_issue & ~freeze;
    assign pop   = wb_valid & wb_ready;

    // At full, a concurrent pop frees the head slot, which is exactly where wr_ptr points.
    assign push_ok    = push & (~full | pop);
    assign push_drop  = push & full & ~pop;
    assign credit_err = issue & (credits == '0) & ~pop;

    assign wb_valid  = ~empty & ~freeze;
    assign wb_rd     = rd_mem[rd_ptr];
    assign wb_data   = data_mem[rd_ptr];
    assign mul_stall = (credits == '0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credits      <= CW'(DEPTH);
            overflow_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                rd_mem[wr_ptr]   <= mul_rd_e3;
                data_mem[wr_ptr] <= mul_result_e3;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Credits saturate at both ends; an issue with no credit left is flagged below.
            case ({issue, pop})
                2'b10: if (credits != '0) credits <= credits - 1'b1;
                2'b01: if (credits != CW'(DEPTH)) credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
            if (push_drop | credit_err) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exu_mul_wb_buf.sv
// tb/tb_exu_mul_wb_buf.sv - queue-model bench driving DEPTH=4 and DEPTH=3 buffers in parallel
module tb_exu_mul_wb_buf;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        freeze = 1'b0;
    logic        mul_issue = 1'b0;
    logic        mul_valid_e3 = 1'b0;
    logic [4:0]  mul_rd_e3 = '0;
    logic [31:0] mul_result_e3 = '0;
    logic        wb_ready = 1'b0;

    logic        wb_valid4, wb_valid3;
    logic [4:0]  wb_rd4, wb_rd3;
    logic [31:0] wb_data4, wb_data3;
    logic        mul_stall4, mul_stall3;
    logic [2:0]  credits4;
    logic [1:0]  credits3;
    logic        overflow_err4, overflow_err3;

    int checks = 0;
    int failures = 0;

    logic [36:0] q4[$];
    logic [36:0] q3[$];
    int          mcr4 = 4;
    int          mcr3 = 3;
    bit          merr4 = 1'b0;
    bit          merr3 = 1'b0;

    always #5 clk = ~clk;

    exu_mul_wb_buf #(.DEPTH(4)) dut (
        .clk(clk), .rst_l(rst_l), .freeze(freeze), .mul_issue(mul_issue),
        .mul_valid_e3(mul_valid_e3), .mul_rd_e3(mul_rd_e3), .mul_result_e3(mul_result_e3),
        .wb_ready(wb_ready), .wb_valid(wb_valid4), .wb_rd(wb_rd4), .wb_data(wb_data4),
        .mul_stall(mul_stall4), .credits(credits4), .overflow_err(overflow_err4)
    );

    exu_mul_wb_buf #(.DEPTH(3)) dut3 (
        .clk(clk), .rst_l(rst_l), .freeze(freeze), .mul_issue(mul_issue),
        .mul_valid_e3(mul_valid_e3), .mul_rd_e3(mul_rd_e3), .mul_result_e3(mul_result_e3),
        .wb_ready(wb_ready), .wb_valid(wb_valid3), .wb_rd(wb_rd3), .wb_data(wb_data3),
        .mul_stall(mul_stall3), .credits(credits3), .overflow_err(overflow_err3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the buffer in queue terms: remove head on handshake, append or drop, move credits.
    task automatic mstep(input int depth, inout logic [36:0] q[$], inout int cr, inout bit err);
        bit was_full, p, u, iss;
        was_full = (q.size() == depth);
        p   = (q.size() > 0) && !freeze && wb_ready;
        u   = mul_valid_e3 && !freeze;
        iss = mul_issue && !freeze;
        if (p) void'(q.pop_front());
        if (u) begin
            if (was_full && !p) err = 1'b1;
            else q.push_back({mul_rd_e3, mul_result_e3});
        end
        cr = cr - int'(iss) + int'(p);
        if (cr < 0) begin
            cr  = 0;
            err = 1'b1;
        end
        if (cr > depth) cr = depth;
    endtask

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q4.delete();
            q3.delete();
            mcr4 = 4;
            mcr3 = 3;
            merr4 = 1'b0;
            merr3 = 1'b0;
        end else begin
            mstep(4, q4, mcr4, merr4);
            mstep(3, q3, mcr3, merr3);
        end
    end

    task automatic cmp(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic st, input int cr, input logic err,
                       input logic [36:0] q[$], input int mcr, input bit merr);
        bit ev;
        ev = (q.size() > 0) && !freeze;
        chk({tag, ".wb_valid"}, 64'(v), 64'(ev));
        if (ev) begin
            chk({tag, ".wb_rd"}, 64'(rd), 64'(q[0][36:32]));
            chk({tag, ".wb_data"}, 64'(d), 64'(q[0][31:0]));
        end
        chk({tag, ".credits"}, 64'(cr), 64'(mcr));
        chk({tag, ".mul_stall"}, 64'(st), 64'(mcr == 0));
        chk({tag, ".overflow_err"}, 64'(err), 64'(merr));
    endtask

    always @(negedge clk) begin
        cmp("d4", wb_valid4, wb_rd4, wb_data4, mul_stall4, int'(credits4), overflow_err4, q4, mcr4, merr4);
        cmp("d3", wb_valid3, wb_rd3, wb_data3, mul_stall3, int'(credits3), overflow_err3, q3, mcr3, merr3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mul_issue = 1'b0;
        mul_valid_e3 = 1'b0;
        wb_ready = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        tick();
        tick();
        rst_l = 1'b1;
        tick();
        chk("t1.wb_valid", 64'(wb_valid4), 64'd0);
        chk("t1.credits", 64'(credits4), 64'd4);
        chk("t1.mul_stall", 64'(mul_stall4), 64'd0);
        chk("t1.overflow_err", 64'(overflow_err4), 64'd0);
        chk("t1.wb_data", 64'(wb_data4), 64'd0);

        // single op: issue, push three cycles later, pop on the following cycle
        mul_issue = 1'b1;
        tick();
        mul_issue = 1'b0;
        chk("t2.credits_after_issue", 64'(credits4), 64'd3);
        tick();
        tick();
        mul_valid_e3 = 1'b1; mul_rd_e3 = 5'd5; mul_result_e3 = 32'h1234_5678; wb_ready = 1'b1;
        #1 chk("t2.no_bypass", 64'(wb_valid4), 64'd0);
        tick();
        mul_valid_e3 = 1'b0;
        chk("t2.wb_valid", 64'(wb_valid4), 64'd1);
        chk("t2.wb_rd", 64'(wb_rd4), 64'd5);
        chk("t2.wb_data", 64'(wb_data4), 64'h1234_5678);
        tick();
        chk("t2.credits_back", 64'(credits4), 64'd4);
        chk("t2.empty", 64'(wb_valid4), 64'd0);

        // back-to-back four issues with writeback blocked
        idle();
        for (int i = 0; i < 4; i++) begin
            mul_issue = 1'b1;
            tick();
        end
        mul_issue = 1'b0;
        chk("t3.credits0", 64'(credits4), 64'd0);
        chk("t3.stall", 64'(mul_stall4), 64'd1);
        chk("t3.d3_err", 64'(overflow_err3), 64'd1);
        for (int i = 0; i < 4; i++) begin
            mul_valid_e3 = 1'b1; mul_rd_e3 = 5'(i + 1); mul_result_e3 = 32'hA + 32'(i);
            tick();
        end
        mul_valid_e3 = 1'b0;
        wb_ready = 1'b1;
        #1 chk("t3.head_A", 64'(wb_data4), 64'hA);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t3.order", 64'(wb_data4), 64'hA + 64'(i));
            if (i == 1) chk("t3.stall_drop", 64'(mul_stall4), 64'd0);
        end
        tick();
        chk("t3.drained", 64'(wb_valid4), 64'd0);
        chk("t3.d4_err", 64'(overflow_err4), 64'd0);

        // wrap and push+pop at full on the DEPTH=3 instance
        idle();
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            mul_issue = 1'b1; mul_valid_e3 = 1'b1;
            mul_rd_e3 = 5'(i + 10); mul_result_e3 = 32'h4000_0000 + 32'(i);
            tick();
        end
        chk("t4.full_head", 64'(wb_data3), 64'h4000_0000);
        for (int i = 3; i < 7; i++) begin
            mul_issue = 1'b1; mul_valid_e3 = 1'b1; wb_ready = 1'b1;
            mul_rd_e3 = 5'(i + 10); mul_result_e3 = 32'h4000_0000 + 32'(i);
            tick();
            chk("t4.full_err", 64'(overflow_err3), 64'd0);
            chk("t4.full_valid", 64'(wb_valid3), 64'd1);
            chk("t4.wrap_order", 64'(wb_data3), 64'h4000_0000 + 64'(i - 2));
        end
        mul_issue = 1'b0; mul_valid_e3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4.drain", 64'(wb_data3), 64'h4000_0004 + 64'(k));
            chk("t4.drain_rd", 64'(wb_rd3), 64'(14 + k));
            tick();
        end
        chk("t4.empty", 64'(wb_valid3), 64'd0);

        // freeze with two entries held
        idle();
        for (int i = 0; i < 2; i++) begin
            mul_issue = 1'b1; mul_valid_e3 = 1'b1;
            mul_rd_e3 = 5'(7 + i); mul_result_e3 = 32'h55 + 32'(i * 17);
            tick();
        end
        freeze = 1'b1; wb_ready = 1'b1; mul_valid_e3 = 1'b1; mul_issue = 1'b1;
        mul_rd_e3 = 5'd9; mul_result_e3 = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5.frozen_valid", 64'(wb_valid4), 64'd0);
            chk("t5.frozen_credits", 64'(credits4), 64'd2);
        end
        freeze = 1'b0; mul_valid_e3 = 1'b0; mul_issue = 1'b0;
        #1 chk("t5.resume_head", 64'(wb_data4), 64'h55);
        chk("t5.resume_valid", 64'(wb_valid4), 64'd1);
        tick();
        chk("t5.second", 64'(wb_data4), 64'h66);
        tick();
        chk("t5.empty", 64'(wb_valid4), 64'd0);
        chk("t5.credits", 64'(credits4), 64'd4);

        // overflow at full, then asynchronous reset mid-cycle
        idle();
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            mul_valid_e3 = 1'b1; mul_rd_e3 = 5'(20 + i); mul_result_e3 = 32'h600 + 32'(i);
            tick();
        end
        mul_valid_e3 = 1'b0;
        chk("t6.err3", 64'(overflow_err3), 64'd1);
        chk("t6.err4", 64'(overflow_err4), 64'd1);
        chk("t6.head3", 64'(wb_data3), 64'h600);
        wb_ready = 1'b1;
        tick();
        chk("t6.intact3", 64'(wb_data3), 64'h601);
        chk("t6.intact4", 64'(wb_data4), 64'h601);
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        chk("t6.rst_valid", 64'(wb_valid3), 64'd0);
        chk("t6.rst_credits3", 64'(credits3), 64'd3);
        chk("t6.rst_credits4", 64'(credits4), 64'd4);
        chk("t6.rst_err", 64'(overflow_err3), 64'd0);
        chk("t6.rst_data", 64'(wb_data3), 64'd0);
        idle();
        tick();
        rst_l = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
